// File: rtl/vga_bit_gen_pkg.sv
// Shared constants and encodings for the tile-based VGA pixel generator.
package vga_bit_gen_pkg;

  localparam int unsigned RGB_W        = 8;
  localparam int unsigned TILE_SIZE    = 8;
  localparam int unsigned TILE_SHIFT   = $clog2(TILE_SIZE);
  localparam int unsigned CODE_W       = 8;
  localparam int unsigned GLYPH_ADDR_W = CODE_W + TILE_SHIFT;
  localparam int unsigned CFG_W        = 16;
  localparam int unsigned PIPE_LAT     = 4;

  localparam logic [RGB_W-1:0] FG_RESET = 8'hFF;
  localparam logic [RGB_W-1:0] BG_RESET = 8'h00;

  typedef enum logic [1:0] {
    CFG_FG     = 2'd0,
    CFG_BG     = 2'd1,
    CFG_CURSOR = 2'd2,
    CFG_CTRL   = 2'd3
  } cfg_sel_e;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep side-band signals aligned with the pixel pipeline.
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one position per clock; every stage resets to RST_VAL.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_bit_gen.sv
// Tile/glyph pixel generator: tile-map fetch, glyph fetch, colour select, blinking cursor.
// Map RAM returns data the cycle after mapAddr; the glyph row is consumed in the
// cycle glyphAddr is presented, giving 4 clocks from input sample to rgb.
import vga_bit_gen_pkg::*;

module vga_bit_gen #(
  parameter int unsigned TILE_COLS    = 80,
  parameter int unsigned ADDR_W       = 13,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic                    clock,
  input  logic                    clear,
  input  logic                    hSync_in,
  input  logic                    vSync_in,
  input  logic                    bright_in,
  input  logic [9:0]              hCount,
  input  logic [9:0]              vCount,
  output logic [ADDR_W-1:0]       mapAddr,
  input  logic [CODE_W-1:0]       mapData,
  output logic [GLYPH_ADDR_W-1:0] glyphAddr,
  input  logic [7:0]              glyphData,
  input  logic                    cfgWe,
  input  logic [1:0]              cfgSel,
  input  logic [CFG_W-1:0]        cfgData,
  output logic                    hSync,
  output logic                    vSync,
  output logic [RGB_W-1:0]        rgb
);

  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [RGB_W-1:0]      fg;
  logic [RGB_W-1:0]      bg;
  logic [ADDR_W-1:0]     cursor_pos;
  logic                  cursor_en;
  logic                  vs_prev;
  logic [BLINK_W-1:0]    blink_count;
  logic                  blink_phase;
  logic [ADDR_W-1:0]     tile_idx_c;
  logic                  match_c;
  logic [TILE_SHIFT-1:0] row_s2;
  logic [TILE_SHIFT-1:0] col_s3;
  logic                  match_s3;
  logic                  bright_s3;
  logic                  glyph_bit_c;
  logic                  cursor_hit_c;
  logic                  pix_c;
  logic                  cfg_unused;

  assign cfg_unused = ^cfgData[CFG_W-1:ADDR_W];

  // Tile index under the current pixel, modulo the map address space.
  assign tile_idx_c = ADDR_W'(vCount[9:TILE_SHIFT]) * ADDR_W'(TILE_COLS)
                    + ADDR_W'(hCount[9:TILE_SHIFT]);
  assign match_c    = (tile_idx_c == cursor_pos);

  // Configuration register writes.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      fg         <= FG_RESET;
      bg         <= BG_RESET;
      cursor_pos <= '0;
      cursor_en  <= 1'b0;
    end else if (cfgWe) begin
      case (cfg_sel_e'(cfgSel))
        CFG_FG:     fg         <= cfgData[RGB_W-1:0];
        CFG_BG:     bg         <= cfgData[RGB_W-1:0];
        CFG_CURSOR: cursor_pos <= cfgData[ADDR_W-1:0];
        CFG_CTRL:   cursor_en  <= cfgData[0];
        default:    ;
      endcase
    end
  end

  // Frame counter for cursor blink, advanced on each vSync_in falling edge.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      vs_prev     <= 1'b1;
      blink_count <= '0;
      blink_phase <= 1'b1;
    end else begin
      vs_prev <= vSync_in;
      if (vs_prev && !vSync_in) begin
        if (blink_count == BLINK_W'(BLINK_FRAMES - 1)) begin
          blink_count <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_count <= blink_count + BLINK_W'(1);
        end
      end
    end
  end

  // Stage 0: tile-map address.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) mapAddr <= '0;
    else       mapAddr <= tile_idx_c;
  end

  // Stage 2: glyph address from returned tile code and aligned glyph row.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) glyphAddr <= '0;
    else       glyphAddr <= {mapData, row_s2};
  end

  assign glyph_bit_c  = glyphData[3'd7 - col_s3];
  assign cursor_hit_c = match_s3 & cursor_en & blink_phase;
  assign pix_c        = glyph_bit_c ^ cursor_hit_c;

  // Stage 3: colour select with blanking.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)          rgb <= '0;
    else if (bright_s3) rgb <= pix_c ? fg : bg;
    else                rgb <= '0;
  end

  vga_delay_line #(.WIDTH(TILE_SHIFT), .DEPTH(PIPE_LAT - 2), .RST_VAL('0)) u_row (
    .clock(clock), .clear(clear), .d(vCount[TILE_SHIFT-1:0]), .q(row_s2)
  );

  vga_delay_line #(.WIDTH(TILE_SHIFT), .DEPTH(PIPE_LAT - 1), .RST_VAL('0)) u_col (
    .clock(clock), .clear(clear), .d(hCount[TILE_SHIFT-1:0]), .q(col_s3)
  );

  vga_delay_line #(.WIDTH(1), .DEPTH(PIPE_LAT - 1), .RST_VAL(1'b0)) u_match (
    .clock(clock), .clear(clear), .d(match_c), .q(match_s3)
  );

  vga_delay_line #(.WIDTH(1), .DEPTH(PIPE_LAT - 1), .RST_VAL(1'b0)) u_bright (
    .clock(clock), .clear(clear), .d(bright_in), .q(bright_s3)
  );

  vga_delay_line #(.WIDTH(1), .DEPTH(PIPE_LAT), .RST_VAL(1'b1)) u_hsync (
    .clock(clock), .clear(clear), .d(hSync_in), .q(hSync)
  );

  vga_delay_line #(.WIDTH(1), .DEPTH(PIPE_LAT), .RST_VAL(1'b1)) u_vsync (
    .clock(clock), .clear(clear), .d(vSync_in), .q(vSync)
  );

endmodule

// File: tb/tb_vga_bit_gen.sv
// Scoreboard bench for vga_bit_gen with behavioural tile-map RAM and glyph ROM.
module tb_vga_bit_gen;

  localparam int unsigned ADDR_W = 13;

  logic              clock = 1'b0;
  logic              clear;
  logic              hSync_in, vSync_in, bright_in;
  logic [9:0]        hCount, vCount;
  logic [ADDR_W-1:0] mapAddr;
  logic [7:0]        mapData;
  logic [10:0]       glyphAddr;
  logic [7:0]        glyphData;
  logic              cfgWe;
  logic [1:0]        cfgSel;
  logic [15:0]       cfgData;
  logic              hSync, vSync;
  logic [7:0]        rgb;

  logic [7:0] map_mem   [8192];
  logic [7:0] glyph_mem [2048];

  vga_bit_gen #(.TILE_COLS(80), .ADDR_W(ADDR_W), .BLINK_FRAMES(32)) dut (
    .clock(clock), .clear(clear),
    .hSync_in(hSync_in), .vSync_in(vSync_in), .bright_in(bright_in),
    .hCount(hCount), .vCount(vCount),
    .mapAddr(mapAddr), .mapData(mapData),
    .glyphAddr(glyphAddr), .glyphData(glyphData),
    .cfgWe(cfgWe), .cfgSel(cfgSel), .cfgData(cfgData),
    .hSync(hSync), .vSync(vSync), .rgb(rgb)
  );

  always #20 clock = ~clock;

  // Synchronous tile-map RAM, combinational glyph ROM read.
  always @(posedge clock) mapData <= map_mem[mapAddr];
  assign glyphData = glyph_mem[glyphAddr];

  typedef struct {
    logic [7:0]        rgb;
    logic              hs;
    logic              vs;
    logic [ADDR_W-1:0] maddr;
    logic [10:0]       gaddr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state mirrored from configuration writes and vSync edges.
  logic [7:0]        m_fg, m_bg;
  logic [ADDR_W-1:0] m_cur;
  logic              m_en, m_phase, m_vs_prev;
  int                m_bcount;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fg = 8'hFF; m_bg = 8'h00; m_cur = '0; m_en = 1'b0;
    m_phase = 1'b1; m_vs_prev = 1'b1; m_bcount = 0;
    sb.delete();
  endtask

  // One pixel clock: check in-flight entries, then drive and predict the next one.
  task automatic step(input logic [9:0] h, input logic [9:0] v, input logic br,
                      input logic hs, input logic vs, input logic we = 1'b0,
                      input logic [1:0] sel = 2'd0, input logic [15:0] data = 16'd0);
    exp_t e;
    int   ti;
    logic [7:0] code, g;
    logic bitv, hit;
    @(negedge clock);
    if (sb.size() >= 1) check("mapAddr", 16'(mapAddr), 16'(sb[sb.size()-1].maddr));
    if (sb.size() >= 3) check("glyphAddr", 16'(glyphAddr), 16'(sb[sb.size()-3].gaddr));
    if (sb.size() == 4) begin
      e = sb.pop_front();
      check("rgb", 16'(rgb), 16'(e.rgb));
      check("hSync", 16'(hSync), 16'(e.hs));
      check("vSync", 16'(vSync), 16'(e.vs));
    end
    hCount = h; vCount = v; bright_in = br; hSync_in = hs; vSync_in = vs;
    cfgWe = we; cfgSel = sel; cfgData = data;
    if (we) begin
      case (sel)
        2'd0: m_fg = data[7:0];
        2'd1: m_bg = data[7:0];
        2'd2: m_cur = data[ADDR_W-1:0];
        default: m_en = data[0];
      endcase
    end
    if (m_vs_prev && !vs) begin
      if (m_bcount == 31) begin m_bcount = 0; m_phase = !m_phase; end
      else m_bcount++;
    end
    m_vs_prev = vs;
    ti      = int'(v >> 3) * 80 + int'(h >> 3);
    e.maddr = ADDR_W'(ti);
    code    = map_mem[e.maddr];
    e.gaddr = {code, v[2:0]};
    g       = glyph_mem[e.gaddr];
    bitv    = g[3'd7 - h[2:0]];
    hit     = (e.maddr == m_cur) && m_en && m_phase;
    e.rgb   = br ? ((bitv ^ hit) ? m_fg : m_bg) : 8'h00;
    e.hs    = hs;
    e.vs    = vs;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) map_mem[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) glyph_mem[i] = 8'($urandom);
    map_mem[81]                = 8'h41;
    glyph_mem[11'h20B]         = 8'h80;
    glyph_mem[{8'h41, 3'd4}]   = 8'h00;

    clear = 1'b1; hSync_in = 1'b1; vSync_in = 1'b1; bright_in = 1'b0;
    hCount = '0; vCount = '0; cfgWe = 1'b0; cfgSel = '0; cfgData = '0;
    model_reset();
    repeat (3) @(negedge clock);
    check("rst_rgb", 16'(rgb), 16'h0000);
    check("rst_hSync", 16'(hSync), 16'h0001);
    check("rst_vSync", 16'(vSync), 16'h0001);
    check("rst_mapAddr", 16'(mapAddr), 16'h0000);
    check("rst_glyphAddr", 16'(glyphAddr), 16'h0000);
    clear = 1'b0;

    // Origin, corner and tile-81 address math.
    step(10'd0, 10'd0, 1'b1, 1'b1, 1'b1);
    step(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
    step(10'd8, 10'd8, 1'b1, 1'b1, 1'b1);

    // Glyph row 3 of code 0x41 across a scanline, with a bright gap and hSync pulse.
    for (int h = 0; h < 24; h++)
      step(10'(h), 10'd11, (h != 12), !(h >= 4 && h <= 6), 1'b1);
    idle(5);

    // Mid-frame clear with non-reset outputs in flight.
    for (int i = 0; i < 6; i++) step(10'd8, 10'd11, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    clear = 1'b1;
    #1;
    check("clr_rgb", 16'(rgb), 16'h0000);
    check("clr_hSync", 16'(hSync), 16'h0001);
    check("clr_mapAddr", 16'(mapAddr), 16'h0000);
    model_reset();
    hSync_in = 1'b1; bright_in = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    for (int h = 8; h < 16; h++) step(10'(h), 10'd11, 1'b1, 1'b1, 1'b1);
    idle(5);

    // Foreground/background colours.
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h00E0);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0003);
    idle(4);
    for (int h = 8; h < 16; h++) step(10'(h), 10'd11, 1'b1, 1'b1, 1'b1);
    idle(5);

    // Blinking cursor on tile 81 over an empty glyph row.
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 16'd81);
    step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 16'h0001);
    idle(4);
    for (int h = 4; h < 20; h++) step(10'(h), 10'd12, 1'b1, 1'b1, 1'b1);
    idle(5);
    for (int f = 0; f < 32; f++) begin
      step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
      step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    end
    idle(4);
    for (int h = 4; h < 20; h++) step(10'(h), 10'd12, 1'b1, 1'b1, 1'b1);
    idle(5);
    // Last falling edge coincides with a foreground write.
    for (int f = 0; f < 32; f++) begin
      if (f == 31) step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 16'h001C);
      else         step(10'd0, 10'd0, 1'b0, 1'b1, 1'b0);
      step(10'd0, 10'd0, 1'b0, 1'b1, 1'b1);
    end
    idle(4);
    for (int h = 4; h < 20; h++) step(10'(h), 10'd12, 1'b1, 1'b1, 1'b1);

    // Random pixels over the active area with random blanking and hSync.
    for (int i = 0; i < 200; i++)
      step(10'($urandom_range(639, 0)), 10'($urandom_range(479, 0)),
           1'($urandom), 1'($urandom), 1'b1);
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
